fifo_frame_writer: RTL and testbench

Write-side framing engine on the wr_clk side of the team's asynchronous FIFO. Accepts a valid/ready payload stream, drives the FIFO write port (wr_en/data/full), and closes every frame with a trailer word that carries a sequence number and the payload length. An optional second trailer word carries an XOR checksum. The read-side deframer uses the trailer to delimit and check frames.

---
 rtl/fifo_frame_writer.sv | 140 ++++++++++++++
 tb/tb_fifo_frame_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_frame_writer.sv
// ============================================================================
// fifo_frame_writer
//   Write-side framing engine: payload stream into the async FIFO, each frame
//   closed by a {seq, len} trailer word, plus an XOR checksum word when the
//   FIFO_FRAME_CSUM_EN macro is defined.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifo_frame_writer #(
    parameter int DATA_WIDTH = 16,
    parameter int SEQ_WIDTH  = 4
) (
    input  logic                  wr_clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  s_ready,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_full,
    output logic                  busy,
    output logic [15:0]           frame_cnt
);

    localparam int LEN_WIDTH = DATA_WIDTH - SEQ_WIDTH;

`ifdef FIFO_FRAME_CSUM_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2,
        CSUM    = 2'd3
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        TRAILER = 2'd2
    } state_t;
`endif

    state_t                 state;
    state_t                 next_state;
    logic [SEQ_WIDTH-1:0]   seq;
    logic [LEN_WIDTH-1:0]   len;
    logic                   accept;
    logic                   trailer_wr;
    logic                   close_frame;
`ifdef FIFO_FRAME_CSUM_EN
    logic [DATA_WIDTH-1:0]  csum;
`endif

    always_comb begin
        next_state  = state;
        s_ready     = 1'b0;
        fifo_wr_en  = 1'b0;
        fifo_data   = '0;
        accept      = 1'b0;
        trailer_wr  = 1'b0;
        close_frame = 1'b0;
        case (state)
            IDLE, PAYLOAD: begin
                s_ready    = !fifo_full;
                accept     = s_valid && !fifo_full;
                fifo_wr_en = accept;
                fifo_data  = s_valid ? s_data : '0;
                if (accept) begin
                    next_state = s_last ? TRAILER : PAYLOAD;
                end
            end
            TRAILER: begin
                fifo_data  = {seq, len};
                fifo_wr_en = !fifo_full;
                trailer_wr = !fifo_full;
                if (trailer_wr) begin
`ifdef FIFO_FRAME_CSUM_EN
                    next_state = CSUM;
`else
                    next_state  = IDLE;
                    close_frame = 1'b1;
`endif
                end
            end
`ifdef FIFO_FRAME_CSUM_EN
            CSUM: begin
                fifo_data  = csum;
                fifo_wr_en = !fifo_full;
                if (!fifo_full) begin
                    next_state  = IDLE;
                    close_frame = 1'b1;
                end
            end
`endif
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            seq       <= '0;
            len       <= '0;
            frame_cnt <= 16'd0;
        end else begin
            state <= next_state;
            // Length saturates so oversize frames still report a usable bound.
            if (accept && (len != {LEN_WIDTH{1'b1}})) begin
                len <= len + 1'b1;
            end
            if (trailer_wr) begin
                seq <= seq + 1'b1;
                len <= '0;
            end
            if (close_frame) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

`ifdef FIFO_FRAME_CSUM_EN
    always_ff @(posedge wr_clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (close_frame) begin
            csum <= '0;
        end else if (accept) begin
            csum <= csum ^ s_data;
        end
    end
`endif

    assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fifo_frame_writer.sv
// ============================================================================
// tb_fifo_frame_writer
//   Scoreboard bench: driver queues expected FIFO words, monitor pops them.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifo_frame_writer;

    logic        wr_clk = 1'b0;
    logic        rst_n  = 1'b0;
    logic        s_valid = 1'b0;
    logic [15:0] s_data  = 16'd0;
    logic        s_last  = 1'b0;
    logic        s_ready;
    logic        fifo_wr_en;
    logic [15:0] fifo_data;
    logic        fifo_full = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    logic [3:0]  m_seq;
    logic [11:0] m_len;
    logic [15:0] m_cnt;
`ifdef FIFO_FRAME_CSUM_EN
    logic [15:0] m_csum;
    localparam int BUBBLES = 2;
`else
    localparam int BUBBLES = 1;
`endif

    fifo_frame_writer #(.DATA_WIDTH(16), .SEQ_WIDTH(4)) dut (
        .wr_clk     (wr_clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .fifo_wr_en (fifo_wr_en),
        .fifo_data  (fifo_data),
        .fifo_full  (fifo_full),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 wr_clk = ~wr_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_data    = 16'd0;
        fifo_full = 1'b0;
        m_seq     = 4'd0;
        m_len     = 12'd0;
        m_cnt     = 16'd0;
`ifdef FIFO_FRAME_CSUM_EN
        m_csum    = 16'd0;
`endif
        #2;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
        chk("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        chk("rst_fifo_data", {16'd0, fifo_data}, 32'd0);
        chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
        @(posedge wr_clk);
        #1 rst_n = 1'b1;
    endtask

    // Presents one beat until accepted; returns the number of refused cycles.
    task automatic send_beat(input logic [15:0] d, input logic last, output int stalls);
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        stalls  = 0;
        acc     = 1'b0;
        exp_q.push_back(d);
        if (m_len != 12'hFFF) m_len = m_len + 12'd1;
`ifdef FIFO_FRAME_CSUM_EN
        m_csum = m_csum ^ d;
`endif
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge wr_clk);
            acc = s_ready;
            if (!acc) stalls++;
            @(posedge wr_clk);
            #1;
        end
        if (!acc) chk("beat_accept_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (last) begin
            exp_q.push_back({m_seq, m_len});
`ifdef FIFO_FRAME_CSUM_EN
            exp_q.push_back(m_csum);
            m_csum = 16'd0;
`endif
            m_seq = m_seq + 4'd1;
            m_len = 12'd0;
            m_cnt = m_cnt + 16'd1;
        end
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            @(negedge wr_clk);
            if (!busy) done = 1'b1;
            else chk("s_ready_in_trailer", {31'd0, s_ready}, 32'd0);
        end
        if (!done) chk("idle_timeout", 32'd0, 32'd1);
        @(posedge wr_clk);
        #1;
    endtask

    initial begin
        int st;
        fork
            forever begin
                @(negedge wr_clk);
                if (rst_n && fifo_wr_en) begin
                    if (fifo_full) chk("wr_while_full", 32'd1, 32'd0);
                    if (exp_q.size() == 0) begin
                        chk("unexpected_write", {16'd0, fifo_data}, 32'hFFFF_FFFF);
                    end else begin
                        chk("fifo_word", {16'd0, fifo_data}, {16'd0, exp_q.pop_front()});
                    end
                end
            end
        join_none

        // 3-beat frame: 0011, 0022, 0044, trailer 0003 (+ csum 0077)
        do_reset();
        send_beat(16'h0011, 1'b0, st);
        send_beat(16'h0022, 1'b0, st);
        send_beat(16'h0044, 1'b1, st);
        wait_idle();
        chk("frame_cnt_single", {16'd0, frame_cnt}, 32'd1);

        // Two 1-beat frames back to back: trailers 0001 then 1001
        do_reset();
        send_beat(16'h00A1, 1'b1, st);
        send_beat(16'h00B2, 1'b1, st);
        chk("bubble_cycles", st, BUBBLES);
        wait_idle();
        chk("frame_cnt_b2b", {16'd0, frame_cnt}, 32'd2);

        // fifo_full stalls mid-payload and during the trailer
        do_reset();
        send_beat(16'h0100, 1'b0, st);
        send_beat(16'h0200, 1'b0, st);
        fifo_full = 1'b1;
        fork
            begin
                repeat (5) @(posedge wr_clk);
                #1 fifo_full = 1'b0;
            end
        join_none
        send_beat(16'h0300, 1'b0, st);
        chk("payload_stall_cycles", st, 32'd5);
        send_beat(16'h0400, 1'b1, st);
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wr_clk);
            chk("trailer_hold_data", {16'd0, fifo_data}, 32'h0004);
            chk("trailer_hold_ready", {31'd0, s_ready}, 32'd0);
            @(posedge wr_clk);
            #1;
        end
        fifo_full = 1'b0;
        wait_idle();

        // 17 frames: the 17th trailer wraps seq to 0
        do_reset();
        for (int f = 0; f < 17; f++) begin
            send_beat(16'h5000 + 16'(f), 1'b1, st);
        end
        wait_idle();
        chk("frame_cnt_17", {16'd0, frame_cnt}, 32'd17);

        // 4100-beat frame: length saturates at FFF
        do_reset();
        for (int i = 0; i < 4100; i++) begin
            send_beat(16'(i), (i == 4099), st);
        end
        wait_idle();

        // Reset during the second beat of a frame
        do_reset();
        send_beat(16'h0B01, 1'b1, st);
        wait_idle();
        send_beat(16'h0C01, 1'b0, st);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        s_valid = 1'b1;
        s_data  = 16'h0C02;
        #2;
        do_reset();
        send_beat(16'h0D01, 1'b0, st);
        send_beat(16'h0D02, 1'b1, st);
        wait_idle();
        chk("frame_cnt_after_rst", {16'd0, frame_cnt}, 32'd1);

        repeat (3) @(posedge wr_clk);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
